// File: rtl/fsk_pkg.sv
// Shared FSK definitions: symbol length, tone-to-bit mapping, demodulator states.
// Used by both the demodulator top level and its zero-crossing detector.
package fsk_pkg;

    localparam int FSK_SAMPLES_PER_SYM = 256;

    localparam logic FSK_BIT_LOW_TONE  = 1'b1;
    localparam logic FSK_BIT_HIGH_TONE = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        ACQ  = 1'b1
    } fsk_state_e;

    // A sample of exactly zero is treated as positive.
    function automatic logic fsk_is_pos(input logic signed [7:0] s);
        return ~s[7];
    endfunction

endpackage

// File: rtl/fsk_zc_detector.sv
// Sign tracker with a one-cycle crossing pulse per accepted sample.
// Optional hysteresis band selected by FSK_DEMOD_HYST_EN.
module fsk_zc_detector
    import fsk_pkg::*;
#(
    parameter int HYST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic signed [7:0] i_sample,
    input  logic              i_valid,
    input  logic              i_init,
    output logic              o_cross
);

    localparam logic signed [7:0] L_HI = 8'(HYST);
    localparam logic signed [7:0] L_LO = 8'(-HYST);

    logic r_sign;
    logic w_next_sign;

`ifdef FSK_DEMOD_HYST_EN
    // Flip only once the sample leaves the dead band; otherwise hold.
    always_comb begin
        w_next_sign = r_sign;
        if (i_sample > L_HI) begin
            w_next_sign = 1'b1;
        end else if (i_sample < L_LO) begin
            w_next_sign = 1'b0;
        end
    end
`else
    logic w_unused_hyst;
    assign w_unused_hyst = ^{L_HI, L_LO};

    // Plain sign of the sample.
    always_comb begin
        w_next_sign = fsk_is_pos(i_sample);
    end
`endif

    // Sync re-seeds from the raw sign; later samples follow the tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign <= 1'b0;
        end else if (i_valid) begin
            r_sign <= i_init ? fsk_is_pos(i_sample) : w_next_sign;
        end
    end

    assign o_cross = i_valid & ~i_init & (w_next_sign != r_sign);

endmodule

// File: rtl/fsk_demodulator.sv
// FSK demodulator: counts zero crossings per symbol window, low count => 1.
// Build option FSK_DEMOD_HYST_EN enables the detector hysteresis band.
module fsk_demodulator
    import fsk_pkg::*;
#(
    parameter int SAMPLES_PER_SYM = FSK_SAMPLES_PER_SYM,
    parameter int CNT_W           = 4,
    parameter int THRESH          = 3,
    parameter int HYST            = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic signed [7:0] sample,
    input  logic              sym_sync,
    output logic              bit_valid,
    output logic              bit_out,
    output logic [CNT_W-1:0]  xcnt,
    output logic              locked
);

    localparam int IDX_W = $clog2(SAMPLES_PER_SYM);

    localparam logic [IDX_W-1:0] L_LAST   = IDX_W'(SAMPLES_PER_SYM - 1);
    localparam logic [IDX_W-1:0] L_ONE    = IDX_W'(1);
    localparam logic [CNT_W-1:0] L_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   L_THRESH = (CNT_W + 1)'(THRESH);

    fsk_state_e r_state;
    fsk_state_e w_state_next;

    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_bit_valid;
    logic             r_bit_out;
    logic [CNT_W-1:0] r_xcnt;

    logic w_init;
    logic w_accept;
    logic w_eos;
    logic w_cross;

    // Sync always wins, even on the last sample of a symbol.
    assign w_init   = sample_valid & sym_sync;
    assign w_accept = sample_valid & ~sym_sync & (r_state == ACQ);
    assign w_eos    = w_accept & (r_idx == L_LAST);

    fsk_zc_detector #(
        .HYST     (HYST)
    ) u_zc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sample (sample),
        .i_valid  (w_init | w_accept),
        .i_init   (w_init),
        .o_cross  (w_cross)
    );

    assign w_cnt_next = (w_cross && (r_cnt != L_MAX)) ? r_cnt + 1'b1 : r_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: any sync enters (or restarts) acquisition.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (w_init) w_state_next = ACQ;
            ACQ:  w_state_next = ACQ;
            default: w_state_next = IDLE;
        endcase
    end

    // Sample index and saturating crossing counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_cnt <= '0;
        end else if (w_init) begin
            r_idx <= L_ONE;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_idx <= r_idx + 1'b1;
            r_cnt <= w_eos ? '0 : w_cnt_next;
        end
    end

    // Decision registers, updated once per completed symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_valid <= 1'b0;
            r_bit_out   <= 1'b0;
            r_xcnt      <= '0;
        end else begin
            r_bit_valid <= w_eos;
            if (w_eos) begin
                r_bit_out <= ({1'b0, w_cnt_next} < L_THRESH) ?
                             FSK_BIT_LOW_TONE : FSK_BIT_HIGH_TONE;
                r_xcnt    <= w_cnt_next;
            end
        end
    end

    assign bit_valid = r_bit_valid;
    assign bit_out   = r_bit_out;
    assign xcnt      = r_xcnt;
    assign locked    = (r_state == ACQ);

endmodule
